// File: rtl/butterfly_inject_scheduler_pkg.sv
// Shared state encodings, sizing helpers and network geometry defaults for butterfly_inject_scheduler.
// Geometry defaults follow the network's BFLY_* macros when they are already defined.
`ifndef BFLY_NUM_CORES
`define BFLY_NUM_CORES 8
`endif
`ifndef BFLY_PACKET_W
`define BFLY_PACKET_W 32
`endif
`ifndef BFLY_BACK_PACKET_W
`define BFLY_BACK_PACKET_W 32
`endif

package butterfly_inject_scheduler_pkg;

   localparam int DEF_N             = `BFLY_NUM_CORES;
   localparam int DEF_PACKET_W      = `BFLY_PACKET_W;
   localparam int DEF_BACK_PACKET_W = `BFLY_BACK_PACKET_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_BACKOFF = 2'd3
   } ch_state_t;

   // Wide enough for the largest load (base << max_retry) + (n - 1) with headroom.
   function automatic int backoff_width(input int base, input int max_retry, input int n);
      return $clog2((base << max_retry) + n) + 1;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/butterfly_inject_scheduler_inject_channel_fsm.sv
// One core's injection channel: 1-cycle accept-to-issue, response registered 1 cycle after the network answers.
// Holds req_ready low while a packet is in flight; retries collisions with a core-staggered backoff.
module inject_channel_fsm
   import butterfly_inject_scheduler_pkg::*;
#(
   parameter int IDX           = 0,
   parameter int N             = DEF_N,
   parameter int PACKET_W      = DEF_PACKET_W,
   parameter int BACK_PACKET_W = DEF_BACK_PACKET_W,
   parameter int MAX_RETRY     = 3,
   parameter int BACKOFF_BASE  = 2,
   parameter int TIMEOUT       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef SCHED_STATS_EN
   output logic                     enter_backoff,
`endif
   input  logic                     req_valid,
   input  logic [PACKET_W-1:0]      req_data,
   output logic                     req_ready,
   output logic [PACKET_W-1:0]      net_data,
   output logic                     net_valid,
   input  logic [BACK_PACKET_W-1:0] back_data,
   input  logic                     back_valid,
   input  logic                     dropped,
   output logic                     rsp_valid,
   output logic [BACK_PACKET_W-1:0] rsp_data,
   output logic                     fail
);

   localparam int BO_W = backoff_width(BACKOFF_BASE, MAX_RETRY, N);
   localparam int RT_W = cnt_width(MAX_RETRY);
   localparam int TM_W = cnt_width(TIMEOUT);

   ch_state_t           state, state_nxt;
   logic [PACKET_W-1:0] pkt;
   logic [RT_W-1:0]     retry_cnt;
   logic [RT_W-1:0]     retry_nxt;
   logic [TM_W-1:0]     timer;
   logic [BO_W-1:0]     backoff;
   logic [BO_W-1:0]     bo_load;
   logic                accept, got_rsp, collide, give_up, retry, bo_done;

   assign accept    = (state == ST_IDLE) && req_valid;
   assign got_rsp   = (state == ST_WAIT) && back_valid;
   // A silent network is treated exactly like an explicit drop.
   assign collide   = (state == ST_WAIT) && !back_valid &&
                      (dropped || (timer == TM_W'(TIMEOUT - 1)));
   assign give_up   = collide && (retry_cnt == RT_W'(MAX_RETRY));
   assign retry     = collide && !give_up;
   assign retry_nxt = retry_cnt + RT_W'(1);
   assign bo_load   = (BO_W'(BACKOFF_BASE) << retry_nxt) + BO_W'(IDX);
   // Leaving when the count steps down to 1 makes the drop-to-reissue gap equal the loaded value.
   assign bo_done   = (state == ST_BACKOFF) && (backoff <= BO_W'(2));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE:   state_nxt = ST_WAIT;
         ST_WAIT:    if (got_rsp || give_up) state_nxt = ST_IDLE;
                     else if (retry)         state_nxt = ST_BACKOFF;
         ST_BACKOFF: if (bo_done) state_nxt = ST_ISSUE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      net_valid = (state == ST_ISSUE);
`ifdef SCHED_STATS_EN
      enter_backoff = retry;
`endif
   end

   assign net_data = pkt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt       <= '0;
         retry_cnt <= '0;
         timer     <= '0;
         backoff   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         fail      <= 1'b0;
      end else begin
         if (accept) begin
            pkt       <= req_data;
            retry_cnt <= '0;
         end else if (retry) begin
            retry_cnt <= retry_nxt;
         end
         if (state == ST_ISSUE)     timer <= '0;
         else if (state == ST_WAIT) timer <= timer + TM_W'(1);
         if (retry)                    backoff <= bo_load;
         else if (state == ST_BACKOFF) backoff <= backoff - BO_W'(1);
         rsp_valid <= got_rsp;
         if (got_rsp) rsp_data <= back_data;
         fail <= give_up;
      end
   end

endmodule

// File: rtl/butterfly_inject_scheduler.sv
// Per-core injection scheduler in front of the butterfly network; slices flat buses into per-core channels.
// Optional SCHED_STATS_EN adds a saturating retry counter; otherwise total_retries is constant zero.
module butterfly_inject_scheduler
   import butterfly_inject_scheduler_pkg::*;
#(
   parameter int N             = DEF_N,
   parameter int PACKET_W      = DEF_PACKET_W,
   parameter int BACK_PACKET_W = DEF_BACK_PACKET_W,
   parameter int MAX_RETRY     = 3,
   parameter int BACKOFF_BASE  = 2,
   parameter int TIMEOUT       = 16,
   parameter int CNT_W         = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               req_valid,
   input  logic [N*PACKET_W-1:0]      req_data,
   output logic [N-1:0]               req_ready,
   output logic [N*PACKET_W-1:0]      net_in_flat,
   output logic [N-1:0]               net_valid_in,
   input  logic [N*BACK_PACKET_W-1:0] net_out_flat,
   input  logic [N-1:0]               net_valid_back_out,
   input  logic [N-1:0]               net_dropped,
   output logic [N-1:0]               rsp_valid,
   output logic [N*BACK_PACKET_W-1:0] rsp_data,
   output logic [N-1:0]               fail,
   output logic [CNT_W-1:0]           total_retries
);

`ifdef SCHED_STATS_EN
   logic [N-1:0] enter_bo;
`endif

   for (genvar i = 0; i < N; i++) begin : g_ch
      inject_channel_fsm #(
         .IDX           (i),
         .N             (N),
         .PACKET_W      (PACKET_W),
         .BACK_PACKET_W (BACK_PACKET_W),
         .MAX_RETRY     (MAX_RETRY),
         .BACKOFF_BASE  (BACKOFF_BASE),
         .TIMEOUT       (TIMEOUT)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
`ifdef SCHED_STATS_EN
         .enter_backoff (enter_bo[i]),
`endif
         .req_valid     (req_valid[i]),
         .req_data      (req_data[i*PACKET_W +: PACKET_W]),
         .req_ready     (req_ready[i]),
         .net_data      (net_in_flat[i*PACKET_W +: PACKET_W]),
         .net_valid     (net_valid_in[i]),
         .back_data     (net_out_flat[i*BACK_PACKET_W +: BACK_PACKET_W]),
         .back_valid    (net_valid_back_out[i]),
         .dropped       (net_dropped[i]),
         .rsp_valid     (rsp_valid[i]),
         .rsp_data      (rsp_data[i*BACK_PACKET_W +: BACK_PACKET_W]),
         .fail          (fail[i])
      );
   end

`ifdef SCHED_STATS_EN
   logic [CNT_W:0] pop, sum;

   always_comb begin
      pop = '0;
      for (int k = 0; k < N; k++) pop = pop + (CNT_W+1)'(enter_bo[k]);
      sum = {1'b0, total_retries} + pop;
   end

   always_ff @(posedge clk) begin
      if (rst)           total_retries <= '0;
      else if (sum[CNT_W]) total_retries <= '1;
      else               total_retries <= sum[CNT_W-1:0];
   end
`else
   assign total_retries = '0;
`endif

endmodule

// File: tb/tb_butterfly_inject_scheduler.sv
// Directed bench for butterfly_inject_scheduler with N=4 and default timing parameters.
module tb_butterfly_inject_scheduler;

   localparam int N  = 4;
   localparam int PW = 32;
   localparam int BW = 32;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*PW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic [N*PW-1:0]   net_in_flat;
   logic [N-1:0]      net_valid_in;
   logic [N*BW-1:0]   net_out_flat;
   logic [N-1:0]      net_valid_back_out;
   logic [N-1:0]      net_dropped;
   logic [N-1:0]      rsp_valid;
   logic [N*BW-1:0]   rsp_data;
   logic [N-1:0]      fail;
   logic [CW-1:0]     total_retries;

   int checks = 0;
   int errors = 0;
   int exp_retries = 0;

   butterfly_inject_scheduler #(
      .N(N), .PACKET_W(PW), .BACK_PACKET_W(BW), .MAX_RETRY(3),
      .BACKOFF_BASE(2), .TIMEOUT(16), .CNT_W(CW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_data           (req_data),
      .req_ready          (req_ready),
      .net_in_flat        (net_in_flat),
      .net_valid_in       (net_valid_in),
      .net_out_flat       (net_out_flat),
      .net_valid_back_out (net_valid_back_out),
      .net_dropped        (net_dropped),
      .rsp_valid          (rsp_valid),
      .rsp_data           (rsp_data),
      .fail               (fail),
      .total_retries      (total_retries)
   );

   always #5 clk = ~clk;

   // Per-core event log sampled mid-cycle; cyc numbers the cycle being observed.
   int cyc = 0;
   int issue_cnt [N];
   int last_issue [N];
   int rsp_cnt [N];
   int fail_cnt [N];

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (net_valid_in[i] === 1'b1) begin
            issue_cnt[i]++;
            last_issue[i] = cyc;
         end
         if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
         if (fail[i] === 1'b1) fail_cnt[i]++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic accept(input int c, input logic [PW-1:0] d);
      req_valid[c] = 1'b1;
      req_data[c*PW +: PW] = d;
      if (req_ready[c] !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready core%0d: got %b expected 1", c, req_ready[c]);
      end
      checks++;
      step();
      req_valid[c] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0; req_data = '0; net_out_flat = '0;
      net_valid_back_out = '0; net_dropped = '0;
      step(); step();
      if (req_ready !== 4'hF) begin errors++; $display("FAIL reset_req_ready: got %h expected f", req_ready); end
      checks++;
      if (net_valid_in !== 4'h0) begin errors++; $display("FAIL reset_net_valid: got %h expected 0", net_valid_in); end
      checks++;
      if ({rsp_valid, fail} !== 8'h00) begin errors++; $display("FAIL reset_rsp_fail: got %h expected 00", {rsp_valid, fail}); end
      checks++;
      if (net_in_flat !== '0 || rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0", net_in_flat, rsp_data); end
      checks++;
      if (total_retries !== '0) begin errors++; $display("FAIL reset_total: got %0d expected 0", total_retries); end
      checks++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_response();
      int low = 0;
      accept(0, 32'hA5A5A5A5);
      // ISSUE cycle
      if (net_valid_in !== 4'b0001 || net_in_flat[0 +: PW] !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL basic_issue: got %b/%h expected 0001/a5a5a5a5", net_valid_in, net_in_flat[0 +: PW]);
      end
      checks++;
      if (req_ready[0] == 1'b0) low++;
      // three silent WAIT cycles, network answers in the fourth cycle after ISSUE
      for (int k = 1; k <= 4; k++) begin
         step();
         if (req_ready[0] == 1'b0) low++;
         if (k == 4) begin
            net_valid_back_out[0] = 1'b1;
            net_out_flat[0 +: BW] = 32'h11;
         end
      end
      step();
      net_valid_back_out[0] = 1'b0;
      if (rsp_valid !== 4'b0001 || rsp_data[0 +: BW] !== 32'h11) begin
         errors++; $display("FAIL basic_rsp: got %b/%h expected 0001/00000011", rsp_valid, rsp_data[0 +: BW]);
      end
      checks++;
      if (low !== 5 || req_ready[0] !== 1'b1) begin
         errors++; $display("FAIL basic_ready_low: got %0d cycles (ready now %b) expected 5 (1)", low, req_ready[0]);
      end
      checks++;
      step();
      if (rsp_valid !== 4'b0000 || rsp_data[0 +: BW] !== 32'h11) begin
         errors++; $display("FAIL basic_rsp_hold: got %b/%h expected 0000/00000011", rsp_valid, rsp_data[0 +: BW]);
      end
      checks++;
      if (total_retries !== CW'(exp_retries)) begin errors++; $display("FAIL basic_total: got %0d expected %0d", total_retries, exp_retries); end
      checks++;
   endtask

   task automatic test_drop_retry();
      int d, base, n;
      accept(2, 32'h0000C0C2);
      step();
      net_dropped[2] = 1'b1;
      d = cyc;
      base = issue_cnt[2];
      step();
      net_dropped[2] = 1'b0;
      n = 0;
      while (issue_cnt[2] == base && n < 40) begin step(); n++; end
      if (issue_cnt[2] == base || last_issue[2] - d !== 6) begin
         errors++; $display("FAIL drop_reissue_gap: got %0d cycles expected 6", last_issue[2] - d);
      end
      checks++;
      step();
      net_valid_back_out[2] = 1'b1;
      net_out_flat[2*BW +: BW] = 32'h22;
      step();
      net_valid_back_out[2] = 1'b0;
`ifdef SCHED_STATS_EN
      exp_retries += 1;
`endif
      if (rsp_valid !== 4'b0100 || rsp_data[2*BW +: BW] !== 32'h22) begin
         errors++; $display("FAIL drop_rsp: got %b/%h expected 0100/00000022", rsp_valid, rsp_data[2*BW +: BW]);
      end
      checks++;
      if (total_retries !== CW'(exp_retries)) begin errors++; $display("FAIL drop_total: got %0d expected %0d", total_retries, exp_retries); end
      checks++;
   endtask

   task automatic test_retry_exhaust();
      int i0, r0, f0;
      logic prev, done, ready_at_fail;
      i0 = issue_cnt[1]; r0 = rsp_cnt[1]; f0 = fail_cnt[1];
      accept(1, 32'h0000BEEF);
      prev = net_valid_in[1];
      done = 1'b0;
      ready_at_fail = 1'b0;
      for (int k = 0; k < 120 && !done; k++) begin
         step();
         net_dropped[1] = prev;
         prev = net_valid_in[1];
         if (fail[1] === 1'b1) begin done = 1'b1; ready_at_fail = req_ready[1]; end
      end
      net_dropped[1] = 1'b0;
`ifdef SCHED_STATS_EN
      exp_retries += 3;
`endif
      if (!done) begin errors++; $display("FAIL exhaust_timeout: no fail within 120 cycles"); end
      checks++;
      if (issue_cnt[1] - i0 !== 4) begin errors++; $display("FAIL exhaust_issues: got %0d expected 4", issue_cnt[1] - i0); end
      checks++;
      step();
      if (fail_cnt[1] - f0 !== 1 || rsp_cnt[1] - r0 !== 0) begin
         errors++; $display("FAIL exhaust_pulses: got fail %0d rsp %0d expected 1/0", fail_cnt[1] - f0, rsp_cnt[1] - r0);
      end
      checks++;
      if (ready_at_fail !== 1'b1 || req_ready[1] !== 1'b1) begin
         errors++; $display("FAIL exhaust_ready: got %b,%b expected 1,1", ready_at_fail, req_ready[1]);
      end
      checks++;
      if (total_retries !== CW'(exp_retries)) begin errors++; $display("FAIL exhaust_total: got %0d expected %0d", total_retries, exp_retries); end
      checks++;
   endtask

   task automatic test_timeout();
      int t, base, n, f0;
      f0 = fail_cnt[3];
      accept(3, 32'h00003333);
      t = cyc;
      base = issue_cnt[3];
      n = 0;
      while (issue_cnt[3] == base && n < 60) begin step(); n++; end
      // 16 WAIT cycles, then backoff (2<<1)+3 = 7
      if (issue_cnt[3] == base || last_issue[3] - t !== 23) begin
         errors++; $display("FAIL timeout_reissue: got %0d cycles expected 23", last_issue[3] - t);
      end
      checks++;
      step();
      net_valid_back_out[3] = 1'b1;
      net_out_flat[3*BW +: BW] = 32'h33;
      step();
      net_valid_back_out[3] = 1'b0;
`ifdef SCHED_STATS_EN
      exp_retries += 1;
`endif
      if (rsp_valid !== 4'b1000 || rsp_data[3*BW +: BW] !== 32'h33 || fail_cnt[3] != f0) begin
         errors++; $display("FAIL timeout_rsp: got %b/%h fails %0d expected 1000/00000033 0", rsp_valid, rsp_data[3*BW +: BW], fail_cnt[3] - f0);
      end
      checks++;
   endtask

   task automatic test_rsp_drop_same_cycle();
      int i0;
      i0 = issue_cnt[0];
      accept(0, 32'h00004444);
      step();
      net_valid_back_out[0] = 1'b1;
      net_dropped[0] = 1'b1;
      net_out_flat[0 +: BW] = 32'h44;
      step();
      net_valid_back_out[0] = 1'b0;
      net_dropped[0] = 1'b0;
      if (rsp_valid !== 4'b0001 || rsp_data[0 +: BW] !== 32'h44 || fail !== 4'b0000) begin
         errors++; $display("FAIL same_cycle_rsp: got %b/%h fail %b expected 0001/00000044 0000", rsp_valid, rsp_data[0 +: BW], fail);
      end
      checks++;
      for (int k = 0; k < 12; k++) step();
      if (issue_cnt[0] - i0 !== 1) begin errors++; $display("FAIL same_cycle_no_retry: got %0d issues expected 1", issue_cnt[0] - i0); end
      checks++;
      if (total_retries !== CW'(exp_retries)) begin errors++; $display("FAIL same_cycle_total: got %0d expected %0d", total_retries, exp_retries); end
      checks++;
   endtask

   task automatic test_spurious_back();
      int i0, r0, f0;
      i0 = issue_cnt[3]; r0 = rsp_cnt[3]; f0 = fail_cnt[3];
      net_valid_back_out[3] = 1'b1;
      net_dropped[3] = 1'b1;
      net_out_flat[3*BW +: BW] = 32'h99;
      step(); step();
      net_valid_back_out[3] = 1'b0;
      net_dropped[3] = 1'b0;
      for (int k = 0; k < 8; k++) step();
      if (rsp_cnt[3] != r0 || fail_cnt[3] != f0 || issue_cnt[3] != i0) begin
         errors++; $display("FAIL spurious_events: got rsp %0d fail %0d issue %0d expected 0 0 0", rsp_cnt[3] - r0, fail_cnt[3] - f0, issue_cnt[3] - i0);
      end
      checks++;
      if (rsp_data[3*BW +: BW] !== 32'h33 || req_ready[3] !== 1'b1) begin
         errors++; $display("FAIL spurious_state: got %h/%b expected 00000033/1", rsp_data[3*BW +: BW], req_ready[3]);
      end
      checks++;
   endtask

   task automatic test_reset_mid_backoff();
      int i0, r0, f0;
      accept(0, 32'h00005555);
      step();
      net_dropped[0] = 1'b1;
      step();
      net_dropped[0] = 1'b0;
      // first BACKOFF cycle: assert reset
      rst = 1'b1;
      step();
      if (req_ready !== 4'hF || net_valid_in !== 4'h0 || rsp_valid !== 4'h0 || fail !== 4'h0) begin
         errors++; $display("FAIL midreset_ctrl: got rdy %h nv %h rv %h f %h expected f 0 0 0", req_ready, net_valid_in, rsp_valid, fail);
      end
      checks++;
      if (net_in_flat !== '0 || rsp_data !== '0 || total_retries !== '0) begin
         errors++; $display("FAIL midreset_data: got %h/%h/%0d expected 0/0/0", net_in_flat, rsp_data, total_retries);
      end
      checks++;
      rst = 1'b0;
      exp_retries = 0;
      i0 = issue_cnt[0]; r0 = rsp_cnt[0]; f0 = fail_cnt[0];
      for (int k = 0; k < 30; k++) step();
      if (issue_cnt[0] != i0 || rsp_cnt[0] != r0 || fail_cnt[0] != f0) begin
         errors++; $display("FAIL midreset_quiet: got issue %0d rsp %0d fail %0d expected 0 0 0", issue_cnt[0] - i0, rsp_cnt[0] - r0, fail_cnt[0] - f0);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_basic_response();
      test_drop_retry();
      test_retry_exhaust();
      test_timeout();
      test_rsp_drop_same_cycle();
      test_spurious_back();
      test_reset_mid_backoff();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/butterfly_inject_scheduler.md
Name: butterfly_inject_scheduler

Overview:
Per-core injection controller in front of the butterfly network. Each core hands over one forward packet at a time through a valid/ready handshake. The block drives the network's flat input bus and watches the backward bus and the dropped-core vector. Collided packets are retried with a deterministic, core-staggered backoff until a response arrives or the retry budget runs out, so cores see a clean request/response interface with guaranteed completion or failure.

Parameters:
N, 8, number of cores; power of two, ≥2
PACKET_W, 32, forward packet width
BACK_PACKET_W, 32, backward packet width
MAX_RETRY, 3, retries after first issue before failing
BACKOFF_BASE, 2, base backoff cycles
TIMEOUT, 16, cycles in WAIT with no response/drop before treating as drop
CNT_W, 16, width of statistics counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  N  core i has a packet
req_data  in  N*PACKET_W  core i packet, slice [i*PACKET_W +: PACKET_W]
req_ready  out  N  core i slot idle
net_in_flat  out  N*PACKET_W  to network in_flat
net_valid_in  out  N  to network valid_in
net_out_flat  in  N*BACK_PACKET_W  from network out_flat
net_valid_back_out  in  N  from network valid_back_out
net_dropped  in  N  from network dropped_core_bus
rsp_valid  out  N  one-cycle response pulse per core
rsp_data  out  N*BACK_PACKET_W  response, held until next response
fail  out  N  one-cycle pulse: retries exhausted
total_retries  out  CNT_W  saturating count of re-issues (see Optional Feature)

Behaviour:
- Reset: all channels IDLE; req_ready=all-ones; net_valid_in, rsp_valid, fail=0; net_in_flat, rsp_data=0; retry and backoff counters=0; total_retries=0. Reset mid-operation abandons in-flight packets and generates no rsp/fail.
- Channels are independent; one FSM per core. States: IDLE, ISSUE, WAIT, BACKOFF.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_data, retry_cnt=0, go to ISSUE next cycle.
- ISSUE: exactly one cycle. net_valid_in[i]=1, net_in_flat slice = latched packet; timer cleared; go to WAIT. net_valid_in is 0 and the slice holds its value in every other state.
- WAIT: timer increments each cycle.
  - net_valid_back_out[i]: capture slice into rsp_data, pulse rsp_valid next cycle, go to IDLE.
  - net_dropped[i], or timer reaches TIMEOUT-1 with neither: if retry_cnt==MAX_RETRY, pulse fail and go to IDLE. Else retry_cnt++, load backoff=(BACKOFF_BASE<<retry_cnt_new)+i, go to BACKOFF.
  - Response and drop in the same cycle: response wins.
- BACKOFF: decrement each cycle. When it reaches 1, go to ISSUE. The minimum gap between re-issues is therefore deterministic.
- net_valid_back_out/net_dropped seen outside WAIT are ignored.
- req_ready=0 from the accept cycle until the cycle after rsp/fail. A new request may be accepted in the same cycle rsp_valid/fail pulses.
- Latency without collision: ISSUE is 1 cycle after accept; rsp_valid is 1 cycle after network response.
- Backoff width: clog2(BACKOFF_BASE<<MAX_RETRY + N)+1 bits; no overflow permitted.

Optional Feature:
SCHED_STATS_EN: when defined, total_retries increments by popcount of channels entering BACKOFF each cycle and saturates at all-ones. When undefined, total_retries is tied to 0 and no counter logic exists.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=0, ISSUE=1, WAIT=2, BACKOFF=3), backoff width function, and PACKET_W/BACK_PACKET_W/N defaults taken from the existing network macros.
- Sub-module inject_channel_fsm, one instance per core via generate. It owns the latch, timer, retry and backoff counters. The top level handles flat-bus slicing and the statistics adder.

Test Plan:
- N=4: core0 req 0xA5A5A5A5; network returns valid_back_out[0] 3 cycles after ISSUE with data 0x11 -> rsp_valid[0] pulses once, rsp_data slice0=0x11, req_ready[0] low for exactly 5 cycles, total_retries=0.
- Core2 request; net_dropped[2] in first WAIT cycle, then response on the 2nd issue -> re-issue exactly BACKOFF_BASE<<1 + 2 = 6 cycles after drop; total_retries=1 (SCHED_STATS_EN).
- Core1 dropped on every issue -> 4 issues total (1+MAX_RETRY), fail[1] pulses once, no rsp_valid, req_ready[1] returns high.
- Core3 issue with no response/drop -> treated as drop after 16 WAIT cycles; re-issue observed.
- Response and drop same cycle on core0 -> rsp_valid, no retry. Spurious valid_back_out on an IDLE core -> ignored.
- Assert rst while core0 is in BACKOFF -> next cycle all outputs at reset values, no later issue, fail or rsp on core0.
